// File: rtl/mw_chk_pkg.sv
// Shared types for the memory-write checker: FSM state encoding and error codes.
package mw_chk_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_PASS = 2'd2,
    ST_FAIL = 2'd3
  } mw_state_t;

  localparam logic [1:0] ERR_NONE     = 2'd0;
  localparam logic [1:0] ERR_MISMATCH = 2'd1;
  localparam logic [1:0] ERR_TIMEOUT  = 2'd2;
  localparam logic [1:0] ERR_EXTRA    = 2'd3;

endpackage

// File: rtl/mw_chk_fifo.sv
// Synchronous FIFO holding expected writes; DEPTH must be a power of two (>= 2)
// so the read/write pointers wrap by natural overflow.
module mw_chk_fifo #(
  parameter int W     = 64,
  parameter int DEPTH = 8
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         push,
  input  logic [W-1:0]                 wdata,
  input  logic                         pop,
  output logic [W-1:0]                 rdata,
  output logic                         full,
  output logic                         empty,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic          push_ok;
  logic          pop_ok;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;
  assign rdata   = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= wdata;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + PW'(1);
      if (pop_ok)  rd_ptr <= rd_ptr + PW'(1);
      case ({push_ok, pop_ok})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/mem_write_checker.sv
// Compares observed memory writes against a preloaded list of expected
// (address, data) pairs, in order, and reports pass / mismatch / timeout / extra write.
//
// state | meaning
// IDLE  | loading expected entries; waits for start with a non-empty list
// RUN   | comparing each unfiltered write against the head entry
// PASS  | every entry matched; any further unfiltered write is an error
// FAIL  | error latched; sticky until reset
module mem_write_checker
  import mw_chk_pkg::*;
#(
  parameter int          DW       = 32,
  parameter int          AW       = 32,
  parameter int          DEPTH    = 8,
  parameter int          TIMEOUT  = 1024,
  parameter int          IGN_EN   = 1,
  parameter int unsigned IGN_ADDR = 80
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         start,
  input  logic                         exp_valid,
  output logic                         exp_ready,
  input  logic [AW-1:0]                exp_addr,
  input  logic [DW-1:0]                exp_data,
  input  logic                         memwrite,
  input  logic [AW-1:0]                dataadr,
  input  logic [DW-1:0]                writedata,
  output logic                         done,
  output logic                         pass,
  output logic                         fail,
  output logic [1:0]                   err_code,
  output logic [AW-1:0]                err_addr,
  output logic [DW-1:0]                err_data,
  output logic [$clog2(DEPTH+1)-1:0]   match_cnt
);

  localparam int CW = $clog2(DEPTH+1);
  localparam int TW = $clog2(TIMEOUT+1);

  mw_state_t     state_q, state_d;
  logic          full, empty;
  logic [CW-1:0] count;
  logic [AW+DW-1:0] head;
  logic [AW-1:0] head_addr;
  logic [DW-1:0] head_data;
  logic          push, pop;
  logic          wr_ign, wr_live, hit, tmo_hit;
  logic [TW-1:0] tmo_q;
  logic          tmo_clr, cnt_inc, err_ld;
  logic [1:0]    err_code_d;
  logic [AW-1:0] err_addr_d;
  logic [DW-1:0] err_data_d;

  assign exp_ready = (state_q == ST_IDLE) && !full;
  assign push      = exp_valid && exp_ready;
  assign {head_addr, head_data} = head;

  mw_chk_fifo #(.W(AW+DW), .DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .wdata ({exp_addr, exp_data}),
    .pop   (pop),
    .rdata (head),
    .full  (full),
    .empty (empty),
    .count (count)
  );

  // Filtered writes are invisible to the checker: they neither compare nor feed the timeout.
  assign wr_ign  = (IGN_EN != 0) && (dataadr == AW'(IGN_ADDR));
  assign wr_live = memwrite && !wr_ign;
  assign hit     = wr_live && (dataadr == head_addr) && (writedata == head_data);
  assign tmo_hit = (tmo_q == TW'(TIMEOUT-1));

  always_comb begin
    state_d    = state_q;
    pop        = 1'b0;
    tmo_clr    = 1'b0;
    cnt_inc    = 1'b0;
    err_ld     = 1'b0;
    err_code_d = ERR_NONE;
    err_addr_d = dataadr;
    err_data_d = writedata;
    case (state_q)
      ST_IDLE: begin
        if (start && !empty) begin
          state_d = ST_RUN;
          tmo_clr = 1'b1;
        end
      end
      ST_RUN: begin
        // A match is checked before the timeout so it wins a same-cycle race.
        if (hit) begin
          pop     = 1'b1;
          cnt_inc = 1'b1;
          tmo_clr = 1'b1;
          if (count == CW'(1)) state_d = ST_PASS;
        end else if (wr_live) begin
          state_d    = ST_FAIL;
          err_ld     = 1'b1;
          err_code_d = ERR_MISMATCH;
        end else if (tmo_hit) begin
          state_d    = ST_FAIL;
          err_ld     = 1'b1;
          err_code_d = ERR_TIMEOUT;
          err_addr_d = head_addr;
          err_data_d = head_data;
        end
      end
      ST_PASS: begin
        if (wr_live) begin
          state_d    = ST_FAIL;
          err_ld     = 1'b1;
          err_code_d = ERR_EXTRA;
        end
      end
      default: state_d = ST_FAIL;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      tmo_q     <= '0;
      match_cnt <= '0;
      done      <= 1'b0;
      pass      <= 1'b0;
      fail      <= 1'b0;
      err_code  <= ERR_NONE;
      err_addr  <= '0;
      err_data  <= '0;
    end else begin
      state_q <= state_d;
      if (tmo_clr)                tmo_q <= '0;
      else if (state_q == ST_RUN) tmo_q <= tmo_q + TW'(1);
      if (cnt_inc) match_cnt <= match_cnt + CW'(1);
      done <= (state_d == ST_PASS) || (state_d == ST_FAIL);
      pass <= (state_d == ST_PASS);
      fail <= (state_d == ST_FAIL);
      if (err_ld) begin
        err_code <= err_code_d;
        err_addr <= err_addr_d;
        err_data <= err_data_d;
      end
    end
  end

endmodule
